pro_run_ctrl: RTL and testbench
===============================

// Module: pro_run_ctrl
// PURPOSE
//  Hardware sequencer for processor bring-up. Three phases:
//   1. Stream a program into instruction memory over addr/wr/wdata.
//   2. Hold working high for a programmed cycle count.
//   3. Walk rID over the register file and return each value on a valid/ready dump port.
//  Sits between a host/debug link and the processor top.
// PARAMETERS
//  DATA_W    32    instruction / register data width
//  ADDR_W    32    processor imem address width
//  IMEM_DEPTH 256  imem words; load beyond this is dropped and flagged
//  NREG      8     registers dumped, rID = 0..NREG-1
//  RID_W     4     rID width; NREG <= 2**RID_W - 1 (all-ones = idle code)
//  CNT_W     16    run-cycle counter width
//  RD_LAT    1     rdata latency after rID change (0 or 1 cycles)
// PORTS
//  clock      in   1        system clock, rising edge
//  reset      in   1        synchronous, active-high
//  start      in   1        pulse: begin LOAD (ignored unless IDLE)
//  abort      in   1        force return to IDLE from any state
//  run_cycles in   CNT_W    working-high cycles, sampled at start
//  ld_valid   in   1        program word valid
//  ld_ready   out  1        sequencer accepts word
//  ld_data    in   DATA_W   program word
//  ld_last    in   1        marks final program word
//  addr       out  ADDR_W   to processor imem address
//  wr         out  1        to processor imem write strobe
//  wdata      out  DATA_W   to processor imem data
//  working    out  1        processor run enable
//  rID        out  RID_W    register-file read select
//  rdata      in   DATA_W   register-file read data
//  dump_valid out  1        dump word valid
//  dump_ready in   1        dump consumer ready
//  dump_id    out  RID_W    register index of dump word
//  dump_data  out  DATA_W   register value
//  busy       out  1        state != IDLE
//  done       out  1        one-cycle pulse on DUMP completion
//  load_ovf   out  1        sticky: word dropped past IMEM_DEPTH; cleared at start
// BEHAVIOUR
//  Reset values: addr=0, wr=0, wdata=0, working=0, rID=all-ones, ld_ready=0,
//   dump_valid=0, dump_id=0, dump_data=0, busy=0, done=0, load_ovf=0; state IDLE.
//  FSM: IDLE -start-> LOAD -ld_last accepted-> RUN -count hit-> DUMP -last id accepted-> IDLE.
//  abort or reset in any state: next edge IDLE, working=0, wr=0, no done pulse.
//  IDLE: ld_ready=0, rID=all-ones. start latches run_cycles, clears wr_ptr and load_ovf.
//  LOAD:
//   - ld_ready=1; word accepted when ld_valid&ld_ready.
//   - Accepted word: next cycle addr=wr_ptr, wdata=ld_data, wr=1, for exactly 1 cycle; wr_ptr++.
//   - wr_ptr>=IMEM_DEPTH: word consumed, wr stays 0, load_ovf set.
//   - ld_last on the accepted word: go to RUN after its write cycle.
//  RUN:
//   - working=1 for exactly run_cycles consecutive cycles, then 0.
//   - run_cycles==0: skip RUN; go directly LOAD->DUMP with working never high.
//   - addr/wr held at 0 while working=1.
//  DUMP:
//   - rID steps 0..NREG-1; each step waits RD_LAT cycles before capturing rdata.
//   - Capture: dump_valid=1, dump_data=rdata, dump_id=rID.
//   - dump_valid/data/id held stable until dump_ready; on the handshake rID advances.
//   - After id NREG-1 accepted: rID=all-ones, done=1 for 1 cycle, state IDLE.
//  start while busy: ignored, no state effect.
//  Counters are unsigned, CNT_W wide, no wrap: RUN ends on count==run_cycles.
// TESTING
//  - Reset: hold reset 2 cycles mid-RUN -> working=0, rID=4'hF, busy=0 next edge.
//  - Load 20 words (0x10F00080..0x22170000), ld_last on the 20th ->
//    wr pulses at addr 0..19 with matching wdata, one per accepted word.
//  - run_cycles=28 -> working high exactly 28 clocks, then DUMP begins.
//  - Dump with dump_ready toggling 1/0 and rdata=0x80+rID -> 8 words, ids 0..7,
//    data 0x80..0x87, stable under backpressure, single done pulse.
//  - IMEM_DEPTH=4, load 6 words -> wr only for addr 0..3, load_ovf=1, flow completes.
//  - run_cycles=0 -> no working pulse; abort asserted mid-DUMP -> IDLE, no done;
//    start during LOAD -> ignored.

Source files
------------

// File: rtl/pro_run_ctrl.sv
// pro_run_ctrl: bring-up sequencer between a host/debug link and a processor top.
//   A start pulse moves IDLE -> LOAD. In LOAD, program words are streamed into imem.
//   The sequencer then holds working high for run_cycles clocks (RUN), reads every
//   register over rID and returns it on a valid/ready dump port (DUMP), pulses done
//   and goes back to IDLE. abort returns to IDLE from any state.
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   start, abort, run_cycles     control; run_cycles is sampled on the start pulse
//   ld_valid/ld_ready/ld_data/ld_last   program word stream
//   addr, wr, wdata              imem write port toward the processor
//   working                      processor run enable
//   rID, rdata                   register-file read select and returned data
//   dump_valid/dump_ready/dump_id/dump_data   register dump stream
//   busy, done, load_ovf         status: not idle, completion pulse, sticky overflow
module pro_run_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int NREG       = 8,
    parameter int RID_W      = 4,
    parameter int CNT_W      = 16,
    parameter int RD_LAT     = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic [DATA_W-1:0] wdata,
    output logic              working,
    output logic [RID_W-1:0]  rID,
    input  logic [DATA_W-1:0] rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [RID_W-1:0]  dump_id,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done,
    output logic              load_ovf
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;

    localparam logic [RID_W-1:0] RID_IDLE = '1;
    localparam logic [RID_W-1:0] RID_LAST = RID_W'(NREG - 1);

    state_t            state;
    logic [CNT_W-1:0]  run_len;   // run_cycles latched at start
    logic [CNT_W-1:0]  run_cnt;   // cycles working has been high, counted 1..run_len
    logic [ADDR_W-1:0] wr_ptr;    // next imem address; stops advancing at IMEM_DEPTH
    logic              lat_cnt;   // remaining read-latency wait before capturing rdata

    // state is a register, so busy is glitch-free without a separate flop
    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            run_len    <= '0;
            run_cnt    <= '0;
            wr_ptr     <= '0;
            lat_cnt    <= 1'b0;
            ld_ready   <= 1'b0;
            addr       <= '0;
            wr         <= 1'b0;
            wdata      <= '0;
            working    <= 1'b0;
            rID        <= RID_IDLE;
            dump_valid <= 1'b0;
            dump_id    <= '0;
            dump_data  <= '0;
            done       <= 1'b0;
            load_ovf   <= 1'b0;
        end else begin
            // wr and done are single-cycle pulses
            wr   <= 1'b0;
            done <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                ld_ready   <= 1'b0;
                addr       <= '0;
                working    <= 1'b0;
                rID        <= RID_IDLE;
                dump_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            run_len  <= run_cycles;
                            wr_ptr   <= '0;
                            load_ovf <= 1'b0;
                            ld_ready <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (!ld_ready) begin
                            // ld_ready drops only after the last word, so this is the
                            // cycle after its write: leave LOAD with addr parked at 0
                            addr <= '0;
                            if (run_len == '0) begin
                                state   <= DUMP;
                                rID     <= '0;
                                lat_cnt <= 1'(RD_LAT);
                            end else begin
                                state   <= RUN;
                                working <= 1'b1;
                                run_cnt <= CNT_W'(1);
                            end
                        end else if (ld_valid) begin
                            if (wr_ptr < ADDR_W'(IMEM_DEPTH)) begin
                                addr   <= wr_ptr;
                                wdata  <= ld_data;
                                wr     <= 1'b1;
                                wr_ptr <= wr_ptr + 1'b1;
                            end else begin
                                // word is consumed but dropped
                                load_ovf <= 1'b1;
                            end
                            if (ld_last)
                                ld_ready <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (run_cnt == run_len) begin
                            working <= 1'b0;
                            state   <= DUMP;
                            rID     <= '0;
                            lat_cnt <= 1'(RD_LAT);
                        end else begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                    DUMP: begin
                        if (dump_valid) begin
                            if (dump_ready) begin
                                dump_valid <= 1'b0;
                                if (rID == RID_LAST) begin
                                    rID   <= RID_IDLE;
                                    done  <= 1'b1;
                                    state <= IDLE;
                                end else begin
                                    rID     <= rID + 1'b1;
                                    lat_cnt <= 1'(RD_LAT);
                                end
                            end
                        end else if (lat_cnt) begin
                            lat_cnt <= 1'b0;
                        end else begin
                            dump_valid <= 1'b1;
                            dump_data  <= rdata;
                            dump_id    <= rID;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pro_run_ctrl.sv
// tb_pro_run_ctrl: randomized bench for pro_run_ctrl. A negedge monitor records the
// imem writes, working cycles, dump handshakes and done pulses. Each test compares
// those records with lists built directly from the stimulus: word i lands at address
// i (below the imem depth), working is high for run_cycles clocks, and register k is
// returned as id k with the register-file value. A second instance with IMEM_DEPTH=4
// shares all inputs and runs in lockstep for the overflow checks.
module tb_pro_run_ctrl;
    localparam int DW = 32, AW = 32, NREG = 8, RW = 4, CW = 16;

    logic          clock = 1'b0;
    logic          reset, start, abort, ld_valid, ld_last, dump_ready, clr_req;
    logic [CW-1:0] run_cycles;
    logic [DW-1:0] ld_data, rdata;
    logic          ld_ready, wr, working, dump_valid, busy, done, load_ovf;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, dump_data;
    logic [RW-1:0] rID, dump_id;
    logic          ld_ready4, wr4, working4, dump_valid4, busy4, done4, load_ovf4;
    logic [AW-1:0] addr4;
    logic [DW-1:0] wdata4, dump_data4;
    logic [RW-1:0] rID4, dump_id4;

    pro_run_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .run_cycles(run_cycles),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .addr(addr), .wr(wr), .wdata(wdata), .working(working), .rID(rID), .rdata(rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_id(dump_id),
        .dump_data(dump_data), .busy(busy), .done(done), .load_ovf(load_ovf)
    );

    pro_run_ctrl #(.IMEM_DEPTH(4)) dut4 (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .run_cycles(run_cycles),
        .ld_valid(ld_valid), .ld_ready(ld_ready4), .ld_data(ld_data), .ld_last(ld_last),
        .addr(addr4), .wr(wr4), .wdata(wdata4), .working(working4), .rID(rID4), .rdata(rdata),
        .dump_valid(dump_valid4), .dump_ready(dump_ready), .dump_id(dump_id4),
        .dump_data(dump_data4), .busy(busy4), .done(done4), .load_ovf(load_ovf4)
    );

    always #5 clock = ~clock;

    // register file with one cycle of read latency
    logic [DW-1:0] rf [NREG];
    always @(posedge clock) rdata <= (rID < RW'(NREG)) ? rf[rID[2:0]] : '0;

    int checks = 0, passed = 0;
    logic [DW-1:0] words [64];

    // ---------------- monitor ----------------
    logic [AW-1:0] wa[$], wa4[$];
    logic [DW-1:0] wd[$], wd4[$], dd[$];
    logic [RW-1:0] di[$];
    int work_cnt, work_pulses, done_cnt, done4_cnt, stab_err, overlap_err, rid_after;
    logic prev_work, prev_hold;
    logic [RW-1:0] prev_id;
    logic [DW-1:0] prev_data;

    always @(negedge clock) begin
        if (clr_req) begin
            wa.delete(); wd.delete(); wa4.delete(); wd4.delete(); di.delete(); dd.delete();
            work_cnt <= 0; work_pulses <= 0; done_cnt <= 0; done4_cnt <= 0;
            stab_err <= 0; overlap_err <= 0; rid_after <= -1;
            prev_work <= 1'b0; prev_hold <= 1'b0;
        end else begin
            if (wr) begin wa.push_back(addr); wd.push_back(wdata); end
            if (wr4) begin wa4.push_back(addr4); wd4.push_back(wdata4); end
            if (wr && working) overlap_err <= overlap_err + 1;
            if (working) work_cnt <= work_cnt + 1;
            if (working && !prev_work) work_pulses <= work_pulses + 1;
            if (prev_work && !working) rid_after <= int'(rID);
            prev_work <= working;
            if (dump_valid && dump_ready) begin di.push_back(dump_id); dd.push_back(dump_data); end
            if (prev_hold && (!dump_valid || dump_id !== prev_id || dump_data !== prev_data))
                stab_err <= stab_err + 1;
            prev_hold <= dump_valid && !dump_ready;
            prev_id   <= dump_id;
            prev_data <= dump_data;
            if (done) done_cnt <= done_cnt + 1;
            if (done4) done4_cnt <= done4_cnt + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_mon();
        @(posedge clock); #1; clr_req = 1'b1;
        @(posedge clock); #1; clr_req = 1'b0;
    endtask

    // start pulse, then stream n words with random gaps; optionally re-pulse start mid-load
    task automatic start_and_load(input int n, input logic [CW-1:0] rc, input bit start_mid);
        int i = 0;
        int guard = 0;
        clear_mon();
        start = 1'b1; run_cycles = rc;
        @(posedge clock); #1;
        start = 1'b0; run_cycles = CW'($urandom);
        while (i < n && guard < 1000) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = words[i];
            ld_last  = (i == n - 1);
            start    = start_mid && (i == n / 2);
            if (start) run_cycles = rc + 16'd5;
            @(negedge clock);
            if (ld_valid && ld_ready) i++;
            @(posedge clock); #1;
            guard++;
        end
        ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
        checks++; if (i != n) $display("FAIL load_accept got %0d words exp %0d", i, n); else passed++;
    endtask

    // run until done (or abort after abort_k dumped words); rmode 0 ready, 1 toggle, 2 random
    task automatic finish_flow(input int rmode, input int abort_k);
        bit fin = 1'b0;
        int guard = 0;
        dump_ready = 1'b0;
        while (!fin && guard < 3000) begin
            case (rmode)
                0:       dump_ready = 1'b1;
                1:       dump_ready = ~dump_ready;
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            if (abort_k > 0 && di.size() >= abort_k) abort = 1'b1;
            @(negedge clock);
            if (done || abort) fin = 1'b1;
            @(posedge clock); #1;
            abort = 1'b0;
            guard++;
        end
        checks++;
        if (!fin) begin
            $display("FAIL flow_timeout got busy=%0b exp done within 3000 cycles", busy);
            abort = 1'b1; @(posedge clock); #1; abort = 1'b0;
        end else passed++;
        repeat (3) @(posedge clock);
        #1; dump_ready = 1'b0;
    endtask

    task automatic fill_words(input int n);
        for (int i = 0; i < n; i++) words[i] = $urandom;
    endtask

    task automatic fill_rf(input bit ramp);
        for (int i = 0; i < NREG; i++) rf[i] = ramp ? DW'(32'h80 + i) : $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int g;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (addr !== '0) $display("FAIL rst_addr got %0h exp 0", addr); else passed++;
        checks++; if (wr !== 1'b0) $display("FAIL rst_wr got %0b exp 0", wr); else passed++;
        checks++; if (wdata !== '0) $display("FAIL rst_wdata got %0h exp 0", wdata); else passed++;
        checks++; if (working !== 1'b0) $display("FAIL rst_working got %0b exp 0", working); else passed++;
        checks++; if (rID !== 4'hF) $display("FAIL rst_rid got %0h exp f", rID); else passed++;
        checks++; if (ld_ready !== 1'b0) $display("FAIL rst_ld_ready got %0b exp 0", ld_ready); else passed++;
        checks++; if (dump_valid !== 1'b0) $display("FAIL rst_dump_valid got %0b exp 0", dump_valid); else passed++;
        checks++; if (dump_id !== '0 || dump_data !== '0) $display("FAIL rst_dump got id %0h data %0h exp 0 0", dump_id, dump_data); else passed++;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_busy_done got %0b %0b exp 0 0", busy, done); else passed++;
        checks++; if (load_ovf !== 1'b0) $display("FAIL rst_load_ovf got %0b exp 0", load_ovf); else passed++;
        @(posedge clock); #1; reset = 1'b0;
        // reset held 2 cycles in the middle of RUN
        fill_words(2);
        start_and_load(2, 16'd50, 1'b0);
        for (g = 0; g < 100; g++) begin @(negedge clock); if (working) break; end
        repeat (5) @(negedge clock);
        checks++; if (working !== 1'b1) $display("FAIL run_entered got %0b exp 1", working); else passed++;
        @(posedge clock); #1; reset = 1'b1;
        @(posedge clock); @(negedge clock);
        checks++; if (working !== 1'b0 || rID !== 4'hF || busy !== 1'b0)
            $display("FAIL midrun_reset got working=%0b rID=%0h busy=%0b exp 0 f 0", working, rID, busy); else passed++;
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0 || ld_ready !== 1'b0) $display("FAIL post_reset got busy=%0b ld_ready=%0b exp 0 0", busy, ld_ready); else passed++;
    endtask

    task automatic test_load_run_dump();
        fill_words(20);
        words[0] = 32'h10F00080; words[19] = 32'h22170000;
        fill_rf(1'b1);
        start_and_load(20, 16'd28, 1'b0);
        finish_flow(1, 0);
        checks++; if (wa.size() != 20) $display("FAIL lrd_write_count got %0d exp 20", wa.size()); else passed++;
        for (int i = 0; i < 20 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== AW'(i) || wd[i] !== words[i])
                $display("FAIL lrd_write[%0d] got addr %0h data %0h exp addr %0h data %0h", i, wa[i], wd[i], i, words[i]); else passed++;
        end
        checks++; if (work_cnt != 28 || work_pulses != 1) $display("FAIL lrd_working got %0d cycles %0d pulses exp 28 1", work_cnt, work_pulses); else passed++;
        checks++; if (rid_after != 0) $display("FAIL lrd_dump_start got rID %0d exp 0", rid_after); else passed++;
        checks++; if (overlap_err != 0) $display("FAIL lrd_wr_while_working got %0d exp 0", overlap_err); else passed++;
        checks++; if (di.size() != NREG) $display("FAIL lrd_dump_count got %0d exp %0d", di.size(), NREG); else passed++;
        for (int k = 0; k < NREG && k < di.size(); k++) begin
            checks++; if (di[k] !== RW'(k) || dd[k] !== DW'(32'h80 + k))
                $display("FAIL lrd_dump[%0d] got id %0h data %0h exp id %0h data %0h", k, di[k], dd[k], k, 32'h80 + k); else passed++;
        end
        checks++; if (stab_err != 0) $display("FAIL lrd_stable got %0d exp 0", stab_err); else passed++;
        checks++; if (done_cnt != 1) $display("FAIL lrd_done got %0d exp 1", done_cnt); else passed++;
        checks++; if (busy !== 1'b0 || rID !== 4'hF || load_ovf !== 1'b0)
            $display("FAIL lrd_end got busy=%0b rID=%0h ovf=%0b exp 0 f 0", busy, rID, load_ovf); else passed++;
    endtask

    task automatic test_overflow();
        fill_words(6);
        fill_rf(1'b0);
        start_and_load(6, CW'($urandom_range(1, 8)), 1'b0);
        finish_flow(2, 0);
        checks++; if (wa4.size() != 4) $display("FAIL ovf_write_count got %0d exp 4", wa4.size()); else passed++;
        for (int i = 0; i < 4 && i < wa4.size(); i++) begin
            checks++; if (wa4[i] !== AW'(i) || wd4[i] !== words[i])
                $display("FAIL ovf_write[%0d] got addr %0h data %0h exp addr %0h data %0h", i, wa4[i], wd4[i], i, words[i]); else passed++;
        end
        checks++; if (load_ovf4 !== 1'b1 || load_ovf !== 1'b0) $display("FAIL ovf_flag got %0b/%0b exp 1/0", load_ovf4, load_ovf); else passed++;
        checks++; if (wa.size() != 6) $display("FAIL ovf_deep_writes got %0d exp 6", wa.size()); else passed++;
        checks++; if (done4_cnt != 1 || busy4 !== 1'b0) $display("FAIL ovf_complete got done=%0d busy=%0b exp 1 0", done4_cnt, busy4); else passed++;
        for (int k = 0; k < NREG && k < di.size(); k++) begin
            checks++; if (di[k] !== RW'(k) || dd[k] !== rf[k])
                $display("FAIL ovf_dump[%0d] got id %0h data %0h exp id %0h data %0h", k, di[k], dd[k], k, rf[k]); else passed++;
        end
        checks++; if (stab_err != 0) $display("FAIL ovf_stable got %0d exp 0", stab_err); else passed++;
    endtask

    task automatic test_zero_run();
        fill_words(3);
        fill_rf(1'b0);
        start_and_load(3, 16'd0, 1'b0);
        finish_flow(0, 0);
        checks++; if (work_cnt != 0 || work_pulses != 0) $display("FAIL zero_working got %0d cycles exp 0", work_cnt); else passed++;
        checks++; if (di.size() != NREG || done_cnt != 1) $display("FAIL zero_dump got %0d words %0d done exp %0d 1", di.size(), done_cnt, NREG); else passed++;
        checks++; if (load_ovf4 !== 1'b0) $display("FAIL zero_ovf_cleared got %0b exp 0", load_ovf4); else passed++;
        checks++; if (wa.size() != 3) $display("FAIL zero_writes got %0d exp 3", wa.size()); else passed++;
    endtask

    task automatic test_start_during_load();
        fill_words(6);
        fill_rf(1'b0);
        start_and_load(6, 16'd7, 1'b1);
        finish_flow(0, 0);
        checks++; if (wa.size() != 6) $display("FAIL sdl_write_count got %0d exp 6", wa.size()); else passed++;
        for (int i = 0; i < 6 && i < wa.size(); i++) begin
            checks++; if (wa[i] !== AW'(i) || wd[i] !== words[i])
                $display("FAIL sdl_write[%0d] got addr %0h data %0h exp addr %0h data %0h", i, wa[i], wd[i], i, words[i]); else passed++;
        end
        checks++; if (work_cnt != 7) $display("FAIL sdl_working got %0d exp 7", work_cnt); else passed++;
        checks++; if (done_cnt != 1) $display("FAIL sdl_done got %0d exp 1", done_cnt); else passed++;
    endtask

    task automatic test_abort_dump();
        fill_words(4);
        fill_rf(1'b0);
        start_and_load(4, 16'd5, 1'b0);
        finish_flow(2, 3);
        checks++; if (done_cnt != 0) $display("FAIL abort_done got %0d exp 0", done_cnt); else passed++;
        checks++; if (busy !== 1'b0 || working !== 1'b0 || rID !== 4'hF || dump_valid !== 1'b0)
            $display("FAIL abort_idle got busy=%0b working=%0b rID=%0h dv=%0b exp 0 0 f 0", busy, working, rID, dump_valid); else passed++;
        checks++; if (di.size() >= NREG) $display("FAIL abort_partial got %0d words exp fewer than %0d", di.size(), NREG); else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int n = $urandom_range(1, 12);
            int rc = $urandom_range(0, 20);
            fill_words(n);
            fill_rf(1'b0);
            start_and_load(n, CW'(rc), 1'b0);
            finish_flow($urandom_range(0, 2), 0);
            checks++; if (wa.size() != n) $display("FAIL rnd%0d_write_count got %0d exp %0d", it, wa.size(), n); else passed++;
            for (int i = 0; i < n && i < wa.size(); i++) begin
                checks++; if (wa[i] !== AW'(i) || wd[i] !== words[i])
                    $display("FAIL rnd%0d_write[%0d] got addr %0h data %0h exp addr %0h data %0h", it, i, wa[i], wd[i], i, words[i]); else passed++;
            end
            checks++; if (work_cnt != rc) $display("FAIL rnd%0d_working got %0d exp %0d", it, work_cnt, rc); else passed++;
            checks++; if (di.size() != NREG) $display("FAIL rnd%0d_dump_count got %0d exp %0d", it, di.size(), NREG); else passed++;
            for (int k = 0; k < NREG && k < di.size(); k++) begin
                checks++; if (di[k] !== RW'(k) || dd[k] !== rf[k])
                    $display("FAIL rnd%0d_dump[%0d] got id %0h data %0h exp id %0h data %0h", it, k, di[k], dd[k], k, rf[k]); else passed++;
            end
            checks++; if (done_cnt != 1 || stab_err != 0) $display("FAIL rnd%0d_done_stable got %0d %0d exp 1 0", it, done_cnt, stab_err); else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        ld_data = '0; dump_ready = 1'b0; run_cycles = '0; clr_req = 1'b0;
        test_reset();
        test_load_run_dump();
        test_overflow();
        test_zero_run();
        test_start_during_load();
        test_abort_dump();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
